// File: rtl/risc32_pkg.sv
// Shared decode constants for the risc32 single-cycle core: opcodes, funct3 codes,
// ALU operation and writeback-source encodings.
package risc32_pkg;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_ALU = 7'b0001000;
    localparam logic [6:0] OP_LUI = 7'b0111011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_INV = 3'b011;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_SRL = 3'b101;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_INV,
        ALU_XOR, ALU_SRL, ALU_OR, ALU_AND
    } alu_op_t;

    typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_IMM, WB_PC4} wb_sel_t;

    function automatic alu_op_t alu_decode(input logic [2:0] f3, input logic f7b5);
        case (f3)
            F3_ADD:  return f7b5 ? ALU_SUB : ALU_ADD;
            F3_SLL:  return ALU_SLL;
            F3_SLT:  return ALU_SLT;
            F3_INV:  return ALU_INV;
            F3_XOR:  return ALU_XOR;
            F3_SRL:  return ALU_SRL;
            F3_OR:   return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/risc32_alu.sv
// Combinational 32-bit ALU; zero flags an all-zero result and drives branch compare.
module risc32_alu
    import risc32_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alu_op_t     alu_op,
    output logic [31:0] result,
    output logic        zero
);

    always_comb begin
        result = '0;
        case (alu_op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_SLL: result = a << b[4:0];
            ALU_SLT: result = {31'b0, $signed(a) < $signed(b)};
            ALU_INV: result = ~a;
            ALU_XOR: result = a ^ b;
            ALU_SRL: result = a >> b[4:0];
            ALU_OR:  result = a | b;
            ALU_AND: result = a & b;
            default: result = '0;
        endcase
    end

    assign zero = (result == 32'd0);

endmodule

// File: rtl/risc32_core.sv
// Single-cycle risc32 CPU: PC, instruction ROM, register file, ALU and data RAM, one instruction per edge.
// Define MEM_INIT_EN to zero im/dm and the register file at time 0.
module risc32_core
    import risc32_pkg::*;
#(
    parameter int ROWS_I = 32,
    parameter int ROWS_D = 32
) (
    input logic clk,
    input logic rst
);

    localparam int IW = $clog2(ROWS_I);
    localparam int DW = $clog2(ROWS_D);

    logic [31:0] pc_current, pc_next, pc_plus4, instr, imm;
    logic [31:0] rs1_val, rs2_val, alu_b, alu_result, load_data, wb_data;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rs1, rs2, rd;
    logic        branch_control, reg_we, mem_we, use_imm, alu_zero;
    alu_op_t     alu_op;
    wb_sel_t     wb_sel;
    logic [IW-1:0] im_idx;
    logic [DW-1:0] dm_idx;

    if (1) begin : im
        logic [31:0] memory [0:ROWS_I-1];
`ifdef MEM_INIT_EN
        initial for (int i = 0; i < ROWS_I; i++) memory[i] = '0;
`endif
    end

    if (1) begin : dm
        logic [31:0] memory [0:ROWS_D-1];
`ifdef MEM_INIT_EN
        initial for (int i = 0; i < ROWS_D; i++) memory[i] = '0;
`endif
        // A reset edge coinciding with a clock edge must not commit the store.
        always_ff @(posedge clk)
            if (!rst && mem_we) memory[dm_idx] <= rs2_val;
    end

    if (1) begin : reg_file
        logic [31:0] reg_array [0:31];
`ifdef MEM_INIT_EN
        initial for (int i = 0; i < 32; i++) reg_array[i] <= '0;
`endif
        always_ff @(posedge clk)
            if (!rst && reg_we && rd != 5'd0) reg_array[rd] <= wb_data;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) pc_current <= '0;
        else     pc_current <= pc_next;

    assign im_idx = IW'((pc_current >> 2) % 32'(ROWS_I));
    assign instr  = im.memory[im_idx];
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];

    assign rs1_val = (rs1 == 5'd0) ? '0 : reg_file.reg_array[rs1];
    assign rs2_val = (rs2 == 5'd0) ? '0 : reg_file.reg_array[rs2];

    always_comb begin
        imm = '0;
        case (opcode)
            OP_LW:   imm = {{20{instr[31]}}, instr[31:20]};
            OP_SW:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OP_BR:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            OP_JAL:  imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            OP_LUI:  imm = {instr[31:12], 12'h000};
            default: imm = '0;
        endcase
    end

    always_comb begin
        alu_op  = ALU_ADD;
        use_imm = 1'b0;
        reg_we  = 1'b0;
        mem_we  = 1'b0;
        wb_sel  = WB_ALU;
        case (opcode)
            OP_LW:  begin use_imm = 1'b1; reg_we = 1'b1; wb_sel = WB_MEM; end
            OP_SW:  begin use_imm = 1'b1; mem_we = 1'b1; end
            OP_ALU: begin alu_op = alu_decode(funct3, instr[30]); reg_we = 1'b1; end
            OP_LUI: begin reg_we = 1'b1; wb_sel = WB_IMM; end
            OP_BR:  alu_op = ALU_SUB;
            OP_JAL: begin reg_we = 1'b1; wb_sel = WB_PC4; end
            default: ;
        endcase
    end

    assign alu_b = use_imm ? imm : rs2_val;

    risc32_alu u_alu (
        .a      (rs1_val),
        .b      (alu_b),
        .alu_op (alu_op),
        .result (alu_result),
        .zero   (alu_zero)
    );

    assign dm_idx    = DW'((alu_result >> 2) % 32'(ROWS_D));
    assign load_data = dm.memory[dm_idx];
    assign pc_plus4  = pc_current + 32'd4;

    always_comb begin
        case (wb_sel)
            WB_MEM:  wb_data = load_data;
            WB_IMM:  wb_data = imm;
            WB_PC4:  wb_data = pc_plus4;
            default: wb_data = alu_result;
        endcase
    end

    // Branch compare reuses the ALU subtract; unlisted funct3 codes never branch.
    assign branch_control = (opcode == OP_JAL) ||
                            ((opcode == OP_BR) && (((funct3 == F3_BEQ) && alu_zero) ||
                                                   ((funct3 == F3_BNE) && !alu_zero)));
    assign pc_next = branch_control ? pc_current + imm : pc_plus4;

endmodule

// File: tb/tb_risc32_core.sv
// Scoreboard bench for risc32_core: programs preloaded hierarchically, expectations queued per instruction.
module tb_risc32_core;
    import risc32_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    risc32_core #(.ROWS_I(32), .ROWS_D(32)) dut (.clk(clk), .rst(rst));

    always #5 clk = ~clk;

    typedef enum {K_REG, K_DM, K_PC, K_PCN, K_BC} kind_e;
    typedef struct {
        string       tag;
        kind_e       kind;
        int          idx;
        logic [31:0] exp;
    } exp_t;

    exp_t pre_q[$];
    exp_t post_q[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] probe(input kind_e k, input int idx);
        case (k)
            K_REG:   return dut.reg_file.reg_array[idx];
            K_DM:    return dut.dm.memory[idx];
            K_PC:    return dut.pc_current;
            K_PCN:   return dut.pc_next;
            default: return {31'b0, dut.branch_control};
        endcase
    endfunction

    task automatic exp_post(input string tag, input kind_e k, input int idx, input logic [31:0] v);
        exp_t e;
        e.tag = tag; e.kind = k; e.idx = idx; e.exp = v;
        post_q.push_back(e);
    endtask

    task automatic exp_pre(input string tag, input kind_e k, input logic [31:0] v);
        exp_t e;
        e.tag = tag; e.kind = k; e.idx = 0; e.exp = v;
        pre_q.push_back(e);
    endtask

    // Pre-edge entries see the combinational next-PC; post-edge entries see committed state.
    task automatic step();
        exp_t e;
        @(negedge clk);
        while (pre_q.size() > 0) begin
            e = pre_q.pop_front();
            check_val(e.tag, probe(e.kind, e.idx), e.exp);
        end
        @(posedge clk);
        #1;
        while (post_q.size() > 0) begin
            e = post_q.pop_front();
            check_val(e.tag, probe(e.kind, e.idx), e.exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0001000};
    endfunction

    function automatic logic [31:0] enc_lw(input logic [11:0] im, input logic [4:0] rs1, input logic [4:0] rd);
        return {im, rs1, 3'b010, rd, 7'b0000011};
    endfunction

    function automatic logic [31:0] enc_sw(input logic [11:0] im, input logic [4:0] rs2, input logic [4:0] rs1);
        return {im[11:5], rs2, rs1, 3'b010, im[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] im, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
        return {im[12], im[10:5], rs2, rs1, f3, im[4:1], im[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] im, input logic [4:0] rd);
        return {im[20], im[10:1], im[11], im[19:12], rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] im, input logic [4:0] rd);
        return {im, rd, 7'b0111011};
    endfunction

    task automatic ld(input int pc, input logic [31:0] w);
        dut.im.memory[pc / 4] <= w;
    endtask

    initial begin
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            dut.im.memory[i]          <= '0;
            dut.dm.memory[i]          <= '0;
            dut.reg_file.reg_array[i] <= '0;
        end
        #1;
        rst = 1'b1;
        #1;
        check_val("reset_pc", dut.pc_current, 32'h0);

        dut.dm.memory[0] <= 32'd1;
        dut.dm.memory[1] <= 32'd2;
        ld(32'h00, enc_lw(12'd0, 5'd0, 5'd3));
        ld(32'h04, enc_lw(12'd4, 5'd0, 5'd1));
        ld(32'h08, enc_r(7'h00, 5'd3, 5'd1, 3'b000, 5'd2));
        ld(32'h0C, enc_sw(12'd4, 5'd2, 5'd0));
        ld(32'h10, enc_r(7'h20, 5'd1, 5'd3, 3'b000, 5'd2));
        ld(32'h14, enc_r(7'h00, 5'd0, 5'd3, 3'b011, 5'd2));
        ld(32'h18, enc_r(7'h00, 5'd1, 5'd3, 3'b001, 5'd2));
        ld(32'h1C, enc_r(7'h00, 5'd1, 5'd3, 3'b101, 5'd2));
        ld(32'h20, enc_r(7'h00, 5'd3, 5'd1, 3'b111, 5'd2));
        ld(32'h24, enc_r(7'h00, 5'd3, 5'd1, 3'b110, 5'd2));
        ld(32'h28, enc_r(7'h00, 5'd1, 5'd3, 3'b010, 5'd2));
        ld(32'h2C, enc_r(7'h00, 5'd3, 5'd1, 3'b100, 5'd2));
        ld(32'h30, enc_b(13'd16, 5'd3, 5'd1, 3'b000));
        ld(32'h34, enc_b(13'd8, 5'd3, 5'd1, 3'b001));
        ld(32'h38, enc_u(20'hDEAD0, 5'd2));
        ld(32'h3C, enc_j(21'(-44), 5'd0));

        @(posedge clk);
        #1;
        rst = 1'b0;

        exp_post("lw_x3", K_REG, 3, 32'd1);            step();
        exp_post("lw_x1", K_REG, 1, 32'd2);            step();
        exp_post("add", K_REG, 2, 32'd3);              step();
        exp_post("sw_dm1", K_DM, 1, 32'd3);            step();
        exp_post("sub", K_REG, 2, 32'hFFFF_FFFF);      step();
        exp_post("inv", K_REG, 2, 32'hFFFF_FFFE);      step();
        exp_post("sll", K_REG, 2, 32'd4);              step();
        exp_post("srl", K_REG, 2, 32'd0);              step();
        exp_post("and", K_REG, 2, 32'd0);              step();
        exp_post("or", K_REG, 2, 32'd3);               step();
        exp_post("slt", K_REG, 2, 32'd1);              step();
        exp_post("xor", K_REG, 2, 32'd3);              step();
        exp_pre("beq_nt_pcn", K_PCN, 32'h34);
        exp_pre("beq_nt_bc", K_BC, 32'd0);
        exp_post("beq_nt_pc", K_PC, 0, 32'h34);        step();
        exp_pre("bne_t_pcn", K_PCN, 32'h3C);
        exp_pre("bne_t_bc", K_BC, 32'd1);
        exp_post("bne_t_pc", K_PC, 0, 32'h3C);         step();
        exp_pre("jal_pcn", K_PCN, 32'h10);
        exp_pre("jal_bc", K_BC, 32'd1);
        exp_post("jal_pc", K_PC, 0, 32'h10);
        exp_post("jal_x0", K_REG, 0, 32'd0);
        exp_post("skip_x2", K_REG, 2, 32'd3);          step();
        exp_post("sub_again", K_REG, 2, 32'hFFFF_FFFF);
        exp_post("sub_again_pc", K_PC, 0, 32'h14);     step();

        // Reset mid-run: the LW at address 0 would load 0x77 into x3 if not suppressed.
        dut.dm.memory[0] <= 32'h77;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("rst_async_pc", dut.pc_current, 32'h0);
        @(posedge clk);
        #1;
        check_val("rst_hold_x3", dut.reg_file.reg_array[3], 32'd1);
        check_val("rst_hold_x2", dut.reg_file.reg_array[2], 32'hFFFF_FFFF);

        dut.dm.memory[0]  <= 32'hA5A5_A5A5;
        dut.dm.memory[2]  <= 32'd1;
        dut.dm.memory[3]  <= 32'h0000_0FFF;
        dut.dm.memory[4]  <= 32'd128;
        dut.dm.memory[5]  <= 32'd124;
        dut.dm.memory[31] <= 32'h1234_5678;
        ld(32'h00, enc_u(20'h55555, 5'd1));
        ld(32'h04, enc_lw(12'd8, 5'd0, 5'd1));
        ld(32'h08, enc_lw(12'd12, 5'd0, 5'd2));
        ld(32'h0C, enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3));
        ld(32'h10, enc_u(20'h12345, 5'd0));
        ld(32'h14, enc_r(7'h00, 5'd1, 5'd0, 3'b000, 5'd4));
        ld(32'h18, enc_lw(12'd16, 5'd0, 5'd2));
        ld(32'h1C, enc_lw(12'd0, 5'd2, 5'd5));
        ld(32'h20, enc_lw(12'd20, 5'd0, 5'd2));
        ld(32'h24, enc_lw(12'd0, 5'd2, 5'd5));
        ld(32'h28, enc_sw(12'd4, 5'd3, 5'd2));
        ld(32'h2C, 32'h0000_01FF);
        ld(32'h30, enc_b(13'(-48), 5'd4, 5'd1, 3'b000));
        rst = 1'b0;

        exp_post("lui", K_REG, 1, 32'h5555_5000);      step();
        exp_post("lw_one", K_REG, 1, 32'd1);           step();
        exp_post("lw_fff", K_REG, 2, 32'h0000_0FFF);   step();
        exp_post("add_carry", K_REG, 3, 32'h0000_1000); step();
        exp_post("x0_write", K_REG, 0, 32'd0);         step();
        exp_post("x0_read", K_REG, 4, 32'd1);          step();
        exp_post("lw_128", K_REG, 2, 32'd128);         step();
        exp_post("wrap_128", K_REG, 5, 32'hA5A5_A5A5); step();
        exp_post("lw_124", K_REG, 2, 32'd124);         step();
        exp_post("wrap_124", K_REG, 5, 32'h1234_5678); step();
        exp_post("sw_wrap", K_DM, 0, 32'h0000_1000);   step();
        exp_pre("bad_op_pcn", K_PCN, 32'h30);
        exp_pre("bad_op_bc", K_BC, 32'd0);
        exp_post("bad_op_x3", K_REG, 3, 32'h0000_1000); step();
        exp_pre("beq_t_pcn", K_PCN, 32'h0);
        exp_pre("beq_t_bc", K_BC, 32'd1);
        exp_post("beq_t_pc", K_PC, 0, 32'h0);          step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
